// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: data width, op codes
// and the FSM state encoding.
package alu_arbiter_pkg;

    localparam int WIDTH = 16;
    localparam int NREQ  = 2;
    localparam int OPW   = 3;

    localparam logic [OPW-1:0] OP_ADD = 3'd0;
    localparam logic [OPW-1:0] OP_SUB = 3'd1;
    localparam logic [OPW-1:0] OP_NOT = 3'd2;
    localparam logic [OPW-1:0] OP_SHL = 3'd3;
    localparam logic [OPW-1:0] OP_SHR = 3'd4;
    localparam logic [OPW-1:0] OP_AND = 3'd5;
    localparam logic [OPW-1:0] OP_OR  = 3'd6;
    localparam logic [OPW-1:0] OP_SLT = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by both requesters. Arithmetic wraps modulo 2^WIDTH;
// shift counts of WIDTH or more produce zero.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   op,
    output logic [WIDTH-1:0] y,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);

    logic             shift_big;
    logic [SHW-1:0]   shamt;

    assign shift_big = |b[WIDTH-1:SHW];
    assign shamt     = b[SHW-1:0];

    always_comb begin
        y = '0;
        case (op)
            OP_ADD: y = a + b;
            OP_SUB: y = a - b;
            OP_NOT: y = ~a;
            OP_SHL: y = shift_big ? '0 : (a << shamt);
            OP_SHR: y = shift_big ? '0 : (a >> shamt);
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_SLT: y = {{(WIDTH-1){1'b0}}, (a < b)};
            default: y = '0;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; one operation in
// flight, fixed IDLE -> EXEC -> RESP sequence, result held until the owner accepts.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREQ  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*3-1:0]     req_op,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_iszero,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    // Handshakes: a request transfers on an edge where req_valid[i] & req_ready[i];
    // a response transfers where rsp_valid[owner] & rsp_ready[owner]. Valid may not
    // depend on ready; ready is only ever raised in IDLE (request) or honoured in RESP.

    state_t            state;
    logic              last_grant;
    logic              owner;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [OPW-1:0]    op_q;
    logic [WIDTH-1:0]  res_q;
    logic              zero_q;

    logic              any_valid;
    logic              grant;
    logic [NREQ-1:0]   hs;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;
    logic [OPW-1:0]    sel_op;
    logic [WIDTH-1:0]  alu_y;
    logic              alu_zero;

    // Grant favours the requester that did not win last when both are pending.
    always_comb begin
        any_valid = |req_valid;
        grant     = (&req_valid) ? ~last_grant : req_valid[1];
        req_ready = (state == ST_IDLE && any_valid) ? onehot2(grant) : '0;
        hs        = req_valid & req_ready;
        sel_a     = grant ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
        sel_b     = grant ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
        sel_op    = grant ? req_op[5:3] : req_op[2:0];
    end

    alu_arbiter_alu u_alu (
        .a    (a_q),
        .b    (b_q),
        .op   (op_q),
        .y    (alu_y),
        .zero (alu_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            res_q      <= '0;
            zero_q     <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|hs) begin
                        a_q        <= sel_a;
                        b_q        <= sel_b;
                        op_q       <= sel_op;
                        owner      <= grant;
                        last_grant <= grant;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    res_q  <= alu_y;
                    zero_q <= alu_zero;
                    state  <= ST_RESP;
                end
                ST_RESP: begin
                    // Returning to IDLE here means no grant is possible this edge.
                    if (rsp_ready[owner]) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid  = (state == ST_RESP) ? onehot2(owner) : '0;
    assign rsp_result = res_q;
    assign rsp_iszero = zero_q;
    assign busy       = (state != ST_IDLE);
    assign dbg_state  = state;

endmodule
